// File: rtl/fpu_addsub_seq.sv
// -----------------------------------------------------------------------------
// fpu_addsub_seq
//   Multi-cycle add/subtract sequencer for the FP unit (binary32 by default).
//   One operand pair is accepted through a valid/ready handshake and walked
//   through UNPACK -> [ALIGN] -> ADD -> [NORM] -> ROUND -> DONE, one shift per
//   cycle. The packed result and flags are held on a valid/ready output until
//   the consumer takes them; only then is a new operand pair accepted.
//
//   Ports
//     clk        : single clock, rising edge
//     rst        : synchronous, active-high reset (discards any operation)
//     in_valid   : operand pair valid
//     in_ready   : high only in IDLE
//     opcode     : 0 = op1 + op2, 1 = op1 - op2
//     op1, op2   : {sign, exp, frac}
//     out_valid  : result/flags valid (DONE)
//     out_ready  : consumer accepts result
//     result     : packed result
//     flags      : {invalid, overflow, underflow}
//     busy       : high in every state except IDLE
// -----------------------------------------------------------------------------
module fpu_addsub_seq #(
   parameter int S = 1,
   parameter int E = 8,
   parameter int M = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             opcode,
   input  logic [S+E+M-1:0] op1,
   input  logic [S+E+M-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [S+E+M-1:0] result,
   output logic [2:0]       flags,
   output logic             busy
);

   localparam int W  = S + E + M;
   localparam int MW = M + 4;            // {hidden, frac, G, R, S}
   localparam int SW = M + 5;            // MW plus carry bit
   localparam int CW = $clog2(M + 4);

   localparam logic [E-1:0]  EXP_ONES   = {E{1'b1}};
   localparam logic [E-1:0]  EXP_ZERO   = {E{1'b0}};
   localparam logic [E-1:0]  EXP_ONE    = {{(E-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
   // Index of the last permitted alignment shift (M+3 shifts in total).
   localparam logic [CW-1:0] ALIGN_LAST = CW'(M + 2);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_ALIGN  = 3'd2,
      ST_ADD    = 3'd3,
      ST_NORM   = 3'd4,
      ST_ROUND  = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Right shift by one keeping everything shifted out in the sticky LSB.
   function automatic logic [MW-1:0] shr_sticky_m(input logic [MW-1:0] v);
      logic [MW-1:0] r;
      r    = {1'b0, v[MW-1:1]};
      r[0] = v[1] | v[0];
      return r;
   endfunction

   function automatic logic [SW-1:0] shr_sticky_s(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      r    = {1'b0, v[SW-1:1]};
      r[0] = v[1] | v[0];
      return r;
   endfunction

   // ---------------------------------------------------------------- state
   state_t        state_q, state_d;
   logic [W-1:0]  op1_q, op1_d;
   logic [W-1:0]  op2_q, op2_d;
   logic          opc_q, opc_d;
   logic          sa_q, sa_d;
   logic          sb_q, sb_d;
   logic          sign_q, sign_d;
   logic [E-1:0]  exp_q, exp_d;
   logic [E-1:0]  ediff_q, ediff_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [MW-1:0] ma_q, ma_d;
   logic [MW-1:0] mb_q, mb_d;
   logic [SW-1:0] mant_q, mant_d;
   logic [W-1:0]  result_q, result_d;
   logic [2:0]    flags_q, flags_d;
   logic          out_valid_q, out_valid_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;

   // ------------------------------------------------- unpack combinational
   logic            sg1_s, sg2_s;
   logic [E-1:0]    e1_s, e2_s, ea_s, eb_s;
   logic [M-1:0]    f1_s, f2_s;
   logic            z1_s, z2_s, nan_s, swap_s;
   logic [E+M-1:0]  mag1_s, mag2_s;
   logic [MW-1:0]   m1_s, m2_s;

   assign sg1_s  = op1_q[W-1];
   assign sg2_s  = op2_q[W-1] ^ opc_q;     // subtract = add with flipped sign
   assign e1_s   = op1_q[E+M-1:M];
   assign e2_s   = op2_q[E+M-1:M];
   assign f1_s   = op1_q[M-1:0];
   assign f2_s   = op2_q[M-1:0];
   assign z1_s   = (e1_s == EXP_ZERO);     // denormals flushed to zero
   assign z2_s   = (e2_s == EXP_ZERO);
   assign nan_s  = (e1_s == EXP_ONES) || (e2_s == EXP_ONES);
   assign mag1_s = z1_s ? {(E+M){1'b0}} : {e1_s, f1_s};
   assign mag2_s = z2_s ? {(E+M){1'b0}} : {e2_s, f2_s};
   assign m1_s   = z1_s ? {MW{1'b0}} : {1'b1, f1_s, 3'b000};
   assign m2_s   = z2_s ? {MW{1'b0}} : {1'b1, f2_s, 3'b000};
   assign swap_s = (mag2_s > mag1_s);
   assign ea_s   = swap_s ? e2_s : e1_s;
   assign eb_s   = swap_s ? e1_s : e2_s;

   // ---------------------------------------------------- add combinational
   logic [SW-1:0] sum_s;
   assign sum_s = (sa_q == sb_q) ? ({1'b0, ma_q} + {1'b0, mb_q})
                                 : ({1'b0, ma_q} - {1'b0, mb_q});

   // -------------------------------------------------- round combinational
   logic          rnd_s, mc_s, ovf_s;
   logic [M+1:0]  mr_s;
   logic [M-1:0]  frac_s;
   logic [E:0]    exp_r_s;

   // Round to nearest even: up when G and (R or S or LSB).
   assign rnd_s   = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
   assign mr_s    = {1'b0, mant_q[SW-2:3]} + {{(M+1){1'b0}}, rnd_s};
   assign mc_s    = mr_s[M+1];
   assign frac_s  = mc_s ? mr_s[M:1] : mr_s[M-1:0];
   assign exp_r_s = {1'b0, exp_q} + {{E{1'b0}}, mc_s};
   assign ovf_s   = (exp_r_s >= {1'b0, EXP_ONES});

   // Next-state and datapath update for every sequencer state.
   always_comb begin
      state_d     = state_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      opc_d       = opc_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      ediff_d     = ediff_q;
      cnt_d       = cnt_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      mant_d      = mant_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               op1_d      = op1;
               op2_d      = op2;
               opc_d      = opcode;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = ST_UNPACK;
            end else begin
               state_d    = ST_IDLE;
            end
         end

         ST_UNPACK: begin
            if (nan_s) begin
               result_d    = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
               flags_d     = 3'b100;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               ma_d    = swap_s ? m2_s  : m1_s;
               mb_d    = swap_s ? m1_s  : m2_s;
               sa_d    = swap_s ? sg2_s : sg1_s;
               sb_d    = swap_s ? sg1_s : sg2_s;
               exp_d   = ea_s;
               ediff_d = ea_s - eb_s;
               cnt_d   = {CW{1'b0}};
               // A zero operand needs no alignment; neither do equal exponents.
               if (z1_s || z2_s || (ea_s == eb_s)) begin
                  state_d = ST_ADD;
               end else begin
                  state_d = ST_ALIGN;
               end
            end
         end

         ST_ALIGN: begin
            mb_d    = shr_sticky_m(mb_q);
            ediff_d = ediff_q - EXP_ONE;
            cnt_d   = cnt_q + CNT_ONE;
            // After M+3 shifts B is sticky-only, so further shifts change nothing.
            if ((ediff_q == EXP_ONE) || (cnt_q == ALIGN_LAST)) begin
               state_d = ST_ADD;
            end else begin
               state_d = ST_ALIGN;
            end
         end

         ST_ADD: begin
            sign_d = sa_q;
            if (sum_s == {SW{1'b0}}) begin
               result_d    = {W{1'b0}};
               flags_d     = 3'b000;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               mant_d = sum_s;
               if (sum_s[SW-1] || !sum_s[SW-2]) begin
                  state_d = ST_NORM;
               end else begin
                  state_d = ST_ROUND;
               end
            end
         end

         ST_NORM: begin
            if (mant_q[SW-1]) begin
               mant_d  = shr_sticky_s(mant_q);
               exp_d   = exp_q + EXP_ONE;
               state_d = ST_ROUND;
            end else if (exp_q == EXP_ONE) begin
               // One more left shift would need exp 0: flush to signed zero.
               result_d    = {sign_q, {(W-1){1'b0}}};
               flags_d     = 3'b001;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               // The sticky bit is replicated so R|S after the shift stays exact.
               mant_d = {mant_q[SW-2:0], mant_q[0]};
               exp_d  = exp_q - EXP_ONE;
               if (mant_q[SW-3]) begin
                  state_d = ST_ROUND;
               end else begin
                  state_d = ST_NORM;
               end
            end
         end

         ST_ROUND: begin
            if (ovf_s) begin
               result_d = {sign_q, EXP_ONES, {M{1'b0}}};
               flags_d  = 3'b010;
            end else begin
               result_d = {sign_q, exp_r_s[E-1:0], frac_s};
               flags_d  = 3'b000;
            end
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end

         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_DONE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Register update with synchronous reset to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op1_q       <= {W{1'b0}};
         op2_q       <= {W{1'b0}};
         opc_q       <= 1'b0;
         sa_q        <= 1'b0;
         sb_q        <= 1'b0;
         sign_q      <= 1'b0;
         exp_q       <= {E{1'b0}};
         ediff_q     <= {E{1'b0}};
         cnt_q       <= {CW{1'b0}};
         ma_q        <= {MW{1'b0}};
         mb_q        <= {MW{1'b0}};
         mant_q      <= {SW{1'b0}};
         result_q    <= {W{1'b0}};
         flags_q     <= 3'b000;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         opc_q       <= opc_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         ediff_q     <= ediff_d;
         cnt_q       <= cnt_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         mant_q      <= mant_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed-vector bench for fpu_addsub_seq. A driver issues operand pairs and
// pushes hand-computed expectations into a scoreboard queue; an independent
// monitor pops and compares whenever the DUT presents a result.
module tb_fpu_addsub_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        opcode;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [2:0]  flags;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;     // -1: latency not checked
      int          stall;   // cycles out_ready is held low
      int          acc;     // cycle count at the accept edge
   } exp_t;

   exp_t sb[$];

   fpu_addsub_seq #(.S(1), .E(8), .M(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .op1       (op1),
      .op2       (op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic opc,
                        input logic [31:0] er, input logic [2:0] ef, input int el,
                        input int st, input int garbage, input bit expect_out);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout actual=in_ready_low expected=in_ready_high");
      end else begin
         op1 = a; op2 = b; opcode = opc; in_valid = 1'b1;
         @(posedge clk);
         #1;
         if (expect_out) begin
            e.res = er; e.flg = ef; e.lat = el; e.stall = st; e.acc = cyc;
            sb.push_back(e);
         end
         @(negedge clk);
         // Operands presented while busy must be ignored.
         op1 = 32'h4049_0FDB; op2 = 32'hC120_0000; opcode = ~opc;
         repeat (garbage) @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Monitor: compares every presented result against the scoreboard head.
   initial begin : monitor
      exp_t e;
      int   held;
      bit   seen;
      bit   post;
      held = 0; seen = 1'b0; post = 1'b0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (post) begin
            post = 1'b0;
            chk("post_hs_out_valid", out_valid, 1'b0);
            chk("post_hs_in_ready",  in_ready,  1'b1);
            chk("post_hs_busy",      busy,      1'b0);
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=%08h expected=none", result);
               out_ready = 1'b1;
            end else begin
               e = sb[0];
               if (!seen) begin
                  seen = 1'b1;
                  if (e.lat >= 0) chk("latency", cyc - e.acc + 1, e.lat);
               end
               if (held < e.stall) begin
                  chk("stall_result",   result,   e.res);
                  chk("stall_flags",    flags,    e.flg);
                  chk("stall_in_ready", in_ready, 1'b0);
                  chk("stall_busy",     busy,     1'b1);
                  held++;
                  out_ready = 1'b0;
               end else begin
                  chk("result", result, e.res);
                  chk("flags",  flags,  e.flg);
                  void'(sb.pop_front());
                  held = 0;
                  seen = 1'b0;
                  post = 1'b1;
                  out_ready = 1'b1;
               end
            end
         end else begin
            out_ready = 1'b0;
         end
      end
   end

   initial begin : stimulus
      int n;
      rst = 1'b1; in_valid = 1'b0; opcode = 1'b0; op1 = 32'h0; op2 = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready",  in_ready,  1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_busy",      busy,      1'b0);
      chk("reset_result",    result,    32'h0);
      chk("reset_flags",     flags,     3'b000);
      rst = 1'b0;

      //     op1           op2           op    result        flags   lat st gb
      issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000,  5, 0, 0, 1'b1); // 1+1
      issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, -1, 0, 0, 1'b1); // 1-1
      issue(32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 3'b000,  6, 0, 0, 1'b1); // 1.5-1.25
      issue(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000, 28, 0, 0, 1'b1); // tie to even
      issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010,  5, 0, 0, 1'b1); // overflow
      issue(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, -1, 5, 3, 1'b1); // NaN, stalled
      issue(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000, 28, 0, 0, 1'b1); // G&R round up
      issue(32'h3F800000, 32'h2F800000, 1'b0, 32'h3F800000, 3'b000, 30, 0, 0, 1'b1); // align cap M+3
      issue(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 29, 0, 0, 1'b1); // 24 norm shifts
      issue(32'h00000000, 32'h40400000, 1'b0, 32'h40400000, 3'b000,  4, 0, 0, 1'b1); // 0+3
      issue(32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 3'b000,  4, 0, 0, 1'b1); // 0-3
      issue(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000,  4, 0, 0, 1'b1); // denormal flush
      issue(32'h40000000, 32'hC0000000, 1'b1, 32'h40800000, 3'b000,  5, 0, 0, 1'b1); // 2-(-2)
      issue(32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 3'b000,  5, 0, 0, 1'b1); // 1-1.5
      issue(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 3'b000, -1, 0, 0, 1'b1); // -1+1 -> +0
      issue(32'h80800001, 32'h00800000, 1'b0, 32'h80000000, 3'b001, -1, 0, 0, 1'b1); // underflow

      // Reset during ALIGN (ediff = 20): operation discarded, no output.
      issue(32'h49800000, 32'h3F800000, 1'b0, 32'h0, 3'b000, -1, 0, 0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready",  in_ready,  1'b1);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_busy",      busy,      1'b0);
      rst = 1'b0;
      issue(32'h49800000, 32'h3F800000, 1'b0, 32'h49800008, 3'b000, 24, 0, 0, 1'b1); // 2^20+1

      n = 0;
      while (sb.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
